// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-latched pending bits, writable mask, fixed priority (bit 0 highest),
// one held request until eret. Define INT_ARB_SYNC_EN to add a 2-flop input synchronizer.
module int_arbiter #(
  parameter int              NSRC       = 4,
  parameter logic [NSRC-1:0] MASK_RESET = {NSRC{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            int_ack,
  input  logic            eret,
  output logic            int_req,
  output logic [2:0]      int_cause,
  output logic            in_service,
  output logic [NSRC-1:0] pending_out,
  output logic [NSRC-1:0] mask_out
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]      state_reg;
  logic [NSRC-1:0] irq_src;
  logic [NSRC-1:0] irq_q_reg;
  logic [NSRC-1:0] pending_reg;
  logic [NSRC-1:0] mask_reg;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pending_next;
  logic [2:0]      sel_idx;
  logic            ack_take;

`ifdef INT_ARB_SYNC_EN
  logic [NSRC-1:0] sync1_reg;
  logic [NSRC-1:0] sync2_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_src = sync2_reg;
`else
  assign irq_src = irq_in;
`endif

  assign rise     = irq_src & ~irq_q_reg;
  assign eligible = pending_reg & mask_reg;
  assign ack_take = (state_reg == REQ) && int_ack;

  // Only the acknowledged source is cleared; a same-cycle rise on it wins.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_clr
      assign clr[gi] = ack_take && (int_cause == 3'(gi));
    end
  endgenerate

  assign pending_next = (pending_reg & ~clr) | rise;

  always_comb begin
    sel_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q_reg   <= '0;
      pending_reg <= '0;
      mask_reg    <= MASK_RESET;
    end else begin
      irq_q_reg   <= irq_src;
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      int_req    <= 1'b0;
      int_cause  <= '0;
      in_service <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (eligible != '0) begin
            state_reg <= REQ;
            int_req   <= 1'b1;
            int_cause <= sel_idx;
          end
        end
        // Request is never retracted; eret here is ignored even alongside int_ack.
        REQ: begin
          if (int_ack) begin
            state_reg  <= SERVICE;
            int_req    <= 1'b0;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (eret) begin
            state_reg  <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          int_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  assign pending_out = pending_reg;
  assign mask_out    = mask_reg;

endmodule

// File: tb/tb_int_arbiter.sv
// Randomized + directed bench for int_arbiter against a behavioural model of the arbitration rules.
module tb_int_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       int_ack;
  logic       eret;
  logic       int_req;
  logic [2:0] int_cause;
  logic       in_service;
  logic [3:0] pending_out;
  logic [3:0] mask_out;

  int n_checks = 0;
  int n_errors = 0;
  int n_cycles = 0;

  // Model: pending/mask as plain sets, handler described by "requesting" / "servicing" flags.
  logic [3:0] m_prev;
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic       m_req;
  logic       m_svc;
  int         m_cause;

  int_arbiter #(.NSRC(4), .MASK_RESET(4'hF)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .eret(eret), .int_req(int_req), .int_cause(int_cause),
    .in_service(in_service), .pending_out(pending_out), .mask_out(mask_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int highest_prio(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_mask = 4'hF; m_req = 0; m_svc = 0; m_cause = 0;
  endtask

  task automatic model_clock(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                             input logic ack, input logic er);
    logic [3:0] rise, elig, clr;
    rise = irq & ~m_prev;
    elig = m_pend & m_mask;
    clr  = '0;
    if (!m_req && !m_svc) begin
      if (elig != 0) begin
        m_req   = 1;
        m_cause = highest_prio(elig);
      end
    end else if (m_req) begin
      if (ack) begin
        m_req = 0;
        m_svc = 1;
        clr[m_cause] = 1'b1;
      end
    end else if (er) begin
      m_svc = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    if (we) m_mask = wd;
    m_prev = irq;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".int_req"},    int_req,     m_req);
    check({tag, ".int_cause"},  int_cause,   m_cause);
    check({tag, ".in_service"}, in_service,  m_svc);
    check({tag, ".pending"},    pending_out, m_pend);
    check({tag, ".mask"},       mask_out,    m_mask);
  endtask

  task automatic cycle(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                       input logic ack, input logic er);
    irq_in = irq; mask_we = we; mask_wdata = wd; int_ack = ack; eret = er;
    @(posedge clk);
    model_clock(irq, we, wd, ack, er);
    #1;
    n_cycles++;
    $display("cyc %0d irq=%b we=%b wd=%b ack=%b eret=%b -> req=%b cause=%0d svc=%b pend=%b mask=%b",
             n_cycles, irq, we, wd, ack, er, int_req, int_cause, in_service, pending_out, mask_out);
    compare_all("cyc");
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst.int_req",    int_req,     1'b0);
    check("rst.in_service", in_service,  1'b0);
    check("rst.pending",    pending_out, 4'h0);
    check("rst.mask",       mask_out,    4'hF);
    check("rst.int_cause",  int_cause,   3'd0);
    irq_in = '0; mask_we = 0; mask_wdata = '0; int_ack = 0; eret = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0] irq_r;
    reset = 1'b1;
    irq_in = '0; mask_we = 0; mask_wdata = '0; int_ack = 0; eret = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset.int_req",    int_req,     1'b0);
    check("reset.pending",    pending_out, 4'h0);
    check("reset.mask",       mask_out,    4'hF);
    check("reset.in_service", in_service,  1'b0);

    // Single source: request two edges after the line rises.
    cycle(4'b0100, 0, 0, 0, 0);
    check("lat.req_early", int_req, 1'b0);
    cycle(4'b0100, 0, 0, 0, 0);
    check("lat.req", int_req, 1'b1);
    check("lat.cause", int_cause, 3'd2);
    cycle(4'b0000, 0, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0, 1);

    // Simultaneous sources: priority, then the loser after eret.
    cycle(4'b1010, 0, 0, 0, 0);
    cycle(4'b1010, 0, 0, 0, 0);
    check("prio.cause", int_cause, 3'd1);
    cycle(4'b0000, 0, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0, 1);
    check("prio.idle", int_req, 1'b0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("prio.req2", int_req, 1'b1);
    check("prio.cause2", int_cause, 3'd3);
    cycle(4'b0000, 0, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0, 1);

    // Masked source stays pending, fires once unmasked.
    cycle(4'b0000, 1, 4'b1110, 0, 0);
    cycle(4'b0001, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("mask.pend", pending_out, 4'b0001);
    check("mask.noreq", int_req, 1'b0);
    cycle(4'b0000, 1, 4'hF, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    check("mask.req", int_req, 1'b1);
    check("mask.cause", int_cause, 3'd0);
    cycle(4'b0000, 0, 0, 1, 0);
    cycle(4'b0000, 0, 0, 0, 1);

    // No retraction in REQ.
    cycle(4'b0100, 0, 0, 0, 0);
    cycle(4'b0100, 0, 0, 0, 0);
    cycle(4'b0001, 1, 4'b0000, 0, 0);
    cycle(4'b0001, 0, 0, 0, 0);
    check("hold.req", int_req, 1'b1);
    check("hold.cause", int_cause, 3'd2);
    cycle(4'b0000, 0, 0, 1, 0);
    check("hold.pend", pending_out, 4'b0001);
    check("hold.svc", in_service, 1'b1);
    // SERVICE ignores ack and accumulates edges.
    cycle(4'b0010, 0, 0, 0, 0);
    cycle(4'b0000, 1, 4'hF, 1, 0);
    check("svc.noreq", int_req, 1'b0);
    check("svc.pend1", pending_out[1], 1'b1);
    #2;
    async_reset_check();

    // ack and eret together in REQ.
    cycle(4'b0100, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 0, 0);
    cycle(4'b0000, 0, 0, 1, 1);
    check("ackeret.svc", in_service, 1'b1);
    cycle(4'b0000, 0, 0, 0, 1);
    check("ackeret.done", in_service, 1'b0);

    // Randomized traffic.
    irq_r = '0;
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) irq_r[b] = ~irq_r[b];
      cycle(irq_r, ($urandom_range(15) == 0), 4'($urandom_range(15)),
            ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      if (n == 250) begin
        #2;
        async_reset_check();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
